vcpu_loader: RTL and testbench
==============================

# vcpu_loader

Boot-time program loader and memory-port owner for the vcpu system. It accepts a length-prefixed byte stream, writes it into `vcpu_mem` from address 0 upward, then hands the memory port to `vcpu_cu` and enables the CPU. It sits between `vcpu_mem`, `vcpu_cu` and a byte source such as a UART receiver or a bench driver. It replaces ad-hoc load/run muxing in system tops.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: memory address width; also the width of the length header.
- `DATA_WIDTH`, default 8: memory and stream byte width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; restarts the load sequence.
- `rxData`  in  DATA_WIDTH  stream byte.
- `rxValid`  in  1  `rxData` is valid.
- `rxReady`  out  1  loader can accept a byte this cycle.
- `cpuRun`  out  1  memory is owned by the CPU and the CPU may execute. Drives the cu `.reset` run-enable.
- `cpuMemClk`, `cpuMemWE`  in  1  CPU memory strobe and write enable.
- `cpuMemAddress`  in  ADDR_WIDTH  CPU memory address.
- `cpuMemData`  in  DATA_WIDTH  CPU write data.
- `cpuMemQ`  out  DATA_WIDTH  memory read data to the CPU; equals `memQ` at all times.
- `memClk`, `memWE`  out  1  to `vcpu_mem`.
- `memAddress`  out  ADDR_WIDTH  to `vcpu_mem`.
- `memData`  out  DATA_WIDTH  to `vcpu_mem`.
- `memQ`  in  DATA_WIDTH  from `vcpu_mem`.

## Operation
- States: LEN_LO → LEN_HI → (DATA_WAIT → WR_SETUP → WR_PULSE)* → RUN.
- A byte is accepted on a rising edge with `rxValid && rxReady`. `rxReady` is 1 only in LEN_LO, LEN_HI and DATA_WAIT, and is 0 while `reset` is high.
- LEN_LO: the accepted byte becomes `len[7:0]`. LEN_HI: the accepted byte becomes `len[15:8]`. The next state is RUN if `len == 0`, otherwise DATA_WAIT.
- DATA_WAIT: the accepted byte is latched into the data register, and the state goes to WR_SETUP.
- WR_SETUP: drives `memAddress = count`, `memData = byte`, `memWE = 1`, `memClk = 0`.
- WR_PULSE: holds the same address, data and `memWE`, with `memClk = 1`. Then `count` increments. The next state is RUN if the new `count == len`, otherwise DATA_WAIT.
- Bytes land at addresses 0 to len−1. `count` never wraps because the maximum `len` is 0xFFFF.
- RUN is terminal until reset. In RUN:
  - `cpuRun = 1`.
  - `mem*` outputs are combinational pass-through of `cpuMem*`.
  - `rxValid` and `rxData` are ignored.
- Outside RUN:
  - `mem*` outputs come from the loader registers.
  - `cpuMem*` inputs are ignored.
  - `cpuRun = 0`.
- `rxValid` gaps stall in DATA_WAIT, LEN_LO or LEN_HI with `memClk = 0` and `memWE = 0`. No spurious writes occur.

## Timing
- Reset values after the edge with `reset = 1`:
  - state LEN_LO
  - `len = 0`, `count = 0`
  - `memClk = 0`, `memWE = 0`, `memAddress = 0`, `memData = 0`
  - `cpuRun = 0`
- `rxReady` is 1 on the first cycle after `reset` deasserts.
- Reset mid-load: the next edge forces the reset values, and any in-flight `memClk` high is dropped. The following header is treated as a fresh load. Written memory is not cleared.
- Reset in RUN: `cpuRun` drops on the next edge. The memory port returns to the loader in the same cycle.
- Throughput is 3 cycles per data byte with `rxValid` held high (DATA_WAIT, WR_SETUP, WR_PULSE).
- Each write is a single rising `memClk` edge, with address, data and WE stable one full cycle before it.
- `cpuRun` rises on the edge ending the last WR_PULSE, or on the edge accepting the high length byte when `len == 0`.
- A full load takes 2 + 3·len cycles from the first accepted byte.
- Loader-side `mem*` outputs and `cpuRun` are registered. The RUN-state mux and the `cpuMemQ` path are combinational.

## Structure
- Add `vcpu_pkg`:
  - state enumeration (LEN_LO, LEN_HI, DATA_WAIT, WR_SETUP, WR_PULSE, RUN)
  - `VCPU_ADDR_WIDTH = 16`, `VCPU_DATA_WIDTH = 8`
- One sub-module, `vcpu_mem_port_mux`: a combinational 2:1 selector of {clk, we, address, data}, selected by `cpuRun`. System tops and benches reuse it.

## Test plan
- Stream 0x10, 0x00, then 50 11 01 22 52 50 05 10 50 12 80 11 77 56 F9 31 with `rxValid` held high.
  - `vcpu_mem[0..15]` holds those bytes in order.
  - `cpuRun` rises exactly 50 cycles after the first accept.
  - The CPU then executes the program: R05 = 0x51, R08 = 0x51, and the loop returns to IP 0.
- Header 0x00, 0x00: `cpuRun` rises on the edge after the second accept; no `memClk` edge occurs.
- Header 0x01, 0x00, then byte 0xAB with 5 idle `rxValid` cycles before it:
  - no `memClk` rise during the gap
  - a single write of 0xAB at address 0
  - `cpuRun` rises after it
- Assert `reset` for 1 cycle in the middle of WR_PULSE of byte 3 of a 16-byte load:
  - `memClk = 0` and `cpuRun = 0` on the next edge
  - a fresh 2-byte load then writes addresses 0–1 and enters RUN
- In RUN, drive `cpuMemAddress = 0x0005`, `cpuMemWE = 1` with toggling `cpuMemClk`, while pulsing `rxValid`:
  - `mem*` outputs mirror the CPU inputs
  - `rxReady = 0` and the loader never writes
  - `cpuMemQ` equals `memQ`

Source files
------------

// File: rtl/vcpu_pkg.sv
// Shared definitions for the vcpu loader: default widths and the loader state set.
package vcpu_pkg;

   localparam int VCPU_ADDR_WIDTH = 16;
   localparam int VCPU_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA_WAIT,
      WR_SETUP,
      WR_PULSE,
      RUN
   } loader_state_e;

   // States in which the loader is willing to take a stream byte.
   function automatic logic state_accepts_byte(input loader_state_e s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA_WAIT);
   endfunction

endpackage

// File: rtl/vcpu_mem_port_mux.sv
// 2:1 selector for the memory port: loader side when sel = 0, CPU side when sel = 1.
module vcpu_mem_port_mux
   import vcpu_pkg::*;
#(
   parameter int ADDR_WIDTH = VCPU_ADDR_WIDTH,
   parameter int DATA_WIDTH = VCPU_DATA_WIDTH
) (
   input  logic                  sel,
   input  logic                  ld_clk,
   input  logic                  ld_we,
   input  logic [ADDR_WIDTH-1:0] ld_address,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  cpu_clk,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0] cpu_data,
   output logic                  mem_clk,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data
);

   // Purely combinational port selection; no state so ownership changes instantly.
   always_comb begin
      if (sel) begin
         mem_clk     = cpu_clk;
         mem_we      = cpu_we;
         mem_address = cpu_address;
         mem_data    = cpu_data;
      end else begin
         mem_clk     = ld_clk;
         mem_we      = ld_we;
         mem_address = ld_address;
         mem_data    = ld_data;
      end
   end

endmodule

// File: rtl/vcpu_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes it to memory from
// address 0, then hands the memory port to the CPU and enables it.
module vcpu_loader
   import vcpu_pkg::*;
#(
   parameter int ADDR_WIDTH = VCPU_ADDR_WIDTH,
   parameter int DATA_WIDTH = VCPU_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] rxData,
   input  logic                  rxValid,
   output logic                  rxReady,
   output logic                  cpuRun,
   input  logic                  cpuMemClk,
   input  logic                  cpuMemWE,
   input  logic [ADDR_WIDTH-1:0] cpuMemAddress,
   input  logic [DATA_WIDTH-1:0] cpuMemData,
   output logic [DATA_WIDTH-1:0] cpuMemQ,
   output logic                  memClk,
   output logic                  memWE,
   output logic [ADDR_WIDTH-1:0] memAddress,
   output logic [DATA_WIDTH-1:0] memData,
   input  logic [DATA_WIDTH-1:0] memQ
);

   loader_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic                  ld_clk_q, ld_clk_d;
   logic                  ld_we_q, ld_we_d;
   logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
   logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
   logic                  run_q, run_d;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] count_inc;

   assign rxReady   = !reset && state_accepts_byte(state_q);
   assign accept    = rxValid && rxReady;
   assign count_inc = count_q + ADDR_WIDTH'(1);
   assign cpuRun    = run_q;
   assign cpuMemQ   = memQ;

   // Next-state and loader-side port values; the write strobe defaults low so
   // stalls never produce a memClk edge.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      count_d   = count_q;
      ld_clk_d  = 1'b0;
      ld_we_d   = 1'b0;
      ld_addr_d = ld_addr_q;
      ld_data_d = ld_data_q;
      run_d     = run_q;
      case (state_q)
         LEN_LO: begin
            if (accept) begin
               len_d   = ADDR_WIDTH'(rxData);
               state_d = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d = len_q | (ADDR_WIDTH'(rxData) << DATA_WIDTH);
               if (len_d == '0) begin
                  state_d = RUN;
                  run_d   = 1'b1;
               end else begin
                  state_d = DATA_WAIT;
               end
            end
         end
         DATA_WAIT: begin
            if (accept) begin
               // Address, data and WE settle a full cycle ahead of the clock rise.
               ld_addr_d = count_q;
               ld_data_d = rxData;
               ld_we_d   = 1'b1;
               state_d   = WR_SETUP;
            end
         end
         WR_SETUP: begin
            ld_we_d  = 1'b1;
            ld_clk_d = 1'b1;
            state_d  = WR_PULSE;
         end
         WR_PULSE: begin
            count_d = count_inc;
            if (count_inc == len_q) begin
               state_d = RUN;
               run_d   = 1'b1;
            end else begin
               state_d = DATA_WAIT;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = LEN_LO;
         end
      endcase
   end

   // State and loader-port registers; reset drops any in-flight write pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LEN_LO;
         len_q     <= '0;
         count_q   <= '0;
         ld_clk_q  <= 1'b0;
         ld_we_q   <= 1'b0;
         ld_addr_q <= '0;
         ld_data_q <= '0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         count_q   <= count_d;
         ld_clk_q  <= ld_clk_d;
         ld_we_q   <= ld_we_d;
         ld_addr_q <= ld_addr_d;
         ld_data_q <= ld_data_d;
         run_q     <= run_d;
      end
   end

   vcpu_mem_port_mux #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_port_mux (
      .sel         (run_q),
      .ld_clk      (ld_clk_q),
      .ld_we       (ld_we_q),
      .ld_address  (ld_addr_q),
      .ld_data     (ld_data_q),
      .cpu_clk     (cpuMemClk),
      .cpu_we      (cpuMemWE),
      .cpu_address (cpuMemAddress),
      .cpu_data    (cpuMemData),
      .mem_clk     (memClk),
      .mem_we      (memWE),
      .mem_address (memAddress),
      .mem_data    (memData)
   );

endmodule

// File: tb/tb_vcpu_loader.sv
// Self-checking bench for vcpu_loader with a behavioural memory behind the port.
module tb_vcpu_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rxData = 8'h00;
   logic        rxValid = 1'b0;
   logic        rxReady;
   logic        cpuRun;
   logic        cpuMemClk = 1'b0;
   logic        cpuMemWE = 1'b0;
   logic [15:0] cpuMemAddress = 16'h0000;
   logic [7:0]  cpuMemData = 8'h00;
   logic [7:0]  cpuMemQ;
   logic        memClk;
   logic        memWE;
   logic [15:0] memAddress;
   logic [7:0]  memData;
   logic [7:0]  memQ;

   vcpu_loader dut (
      .clk           (clk),
      .reset         (reset),
      .rxData        (rxData),
      .rxValid       (rxValid),
      .rxReady       (rxReady),
      .cpuRun        (cpuRun),
      .cpuMemClk     (cpuMemClk),
      .cpuMemWE      (cpuMemWE),
      .cpuMemAddress (cpuMemAddress),
      .cpuMemData    (cpuMemData),
      .cpuMemQ       (cpuMemQ),
      .memClk        (memClk),
      .memWE         (memWE),
      .memAddress    (memAddress),
      .memData       (memData),
      .memQ          (memQ)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural memory: writes on each rising memClk with memWE high.
   logic [7:0] mem_arr [0:65535];
   assign memQ = mem_arr[memAddress];

   logic [7:0] exp_bytes [0:63];
   int         gaps [0:63];
   int         wr_cnt = 0;
   bit         loader_phase = 1'b0;

   // Every loader write must land at the next sequential address with the next stream byte.
   always @(posedge memClk) begin
      if (memWE) mem_arr[memAddress] = memData;
      if (loader_phase) begin
         check("wr_we", int'(memWE), 1);
         check("wr_addr", int'(memAddress), wr_cnt);
         if (wr_cnt < 64) check("wr_data", int'(memData), int'(exp_bytes[wr_cnt]));
         wr_cnt++;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      rxValid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   // Waits for rxReady, idles gap ready cycles, then presents b until accepted.
   task automatic send(input logic [7:0] b, input int gap, output int acc_cyc);
      int n;
      n = 0;
      rxValid = 1'b0;
      while (!rxReady && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (gap) @(negedge clk);
      rxData = b;
      rxValid = 1'b1;
      #1;
      if (!rxReady) begin
         check("rx_ready_timeout", int'(rxReady), 1);
         acc_cyc = cyc;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      @(negedge clk);
   endtask

   // Streams a header plus exp_bytes[0..len-1] with gaps[], checks writes and memory,
   // returns the cycle count from first accept through the cpuRun rising edge.
   task automatic run_load(input int len, output int cycles);
      int t0, t, n;
      logic [15:0] lenv;
      lenv = 16'(len);
      wr_cnt = 0;
      loader_phase = 1'b1;
      send(lenv[7:0], 0, t0);
      send(lenv[15:8], 0, t);
      for (int i = 0; i < len; i++) send(exp_bytes[i], gaps[i], t);
      rxValid = 1'b0;
      n = 0;
      while (!cpuRun && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("cpu_run_rise", int'(cpuRun), 1);
      cycles = cyc - t0 + 1;
      loader_phase = 1'b0;
      check("wr_count", wr_cnt, len);
      for (int i = 0; i < len; i++) check("mem_content", int'(mem_arr[i]), int'(exp_bytes[i]));
   endtask

   typedef struct {
      int len;
      int gap;
      int seed;
      int exp_cycles;
   } vec_t;

   vec_t tbl [6];

   logic [7:0] prog [0:15];

   initial begin
      int c, t, exp_c, len;
      int wr_before;

      tbl[0] = '{0, 0, 8'h00, 2};
      tbl[1] = '{1, 0, 8'h11, 5};
      tbl[2] = '{1, 5, 8'hAB, 10};
      tbl[3] = '{3, 0, 8'h20, 11};
      tbl[4] = '{4, 2, 8'h40, 22};
      tbl[5] = '{2, 1, 8'hF0, 10};

      prog = '{8'h50, 8'h11, 8'h01, 8'h22, 8'h52, 8'h50, 8'h05, 8'h10,
               8'h50, 8'h12, 8'h80, 8'h11, 8'h77, 8'h56, 8'hF9, 8'h31};

      // Loader-side cpuMem* junk must be ignored; cpuMemClk stays low during loads.
      cpuMemAddress = 16'hBEEF;
      cpuMemData = 8'hEE;
      cpuMemWE = 1'b1;
      cpuMemClk = 1'b0;

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_memClk", int'(memClk), 0);
      check("rst_memWE", int'(memWE), 0);
      check("rst_memAddress", int'(memAddress), 0);
      check("rst_memData", int'(memData), 0);
      check("rst_cpuRun", int'(cpuRun), 0);
      check("rst_rxReady", int'(rxReady), 0);
      reset = 1'b0;
      #1;
      check("rxReady_after_reset", int'(rxReady), 1);

      // Reference program load with rxValid held high.
      for (int i = 0; i < 16; i++) begin
         exp_bytes[i] = prog[i];
         gaps[i] = 0;
      end
      run_load(16, c);
      check("prog_cycles", c, 50);
      $display("prog load: len=16 cycles=%0d", c);

      // Table of header/gap scenarios with fixed expected latencies.
      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int k = 0; k < tbl[v].len; k++) begin
            exp_bytes[k] = 8'(tbl[v].seed + 13 * k);
            gaps[k] = tbl[v].gap;
         end
         run_load(tbl[v].len, c);
         check("tbl_cycles", c, tbl[v].exp_cycles);
         $display("vector %0d: len=%0d gap=%0d cycles=%0d", v, tbl[v].len, tbl[v].gap, c);
      end

      // Randomized loads against the latency model: 2 header cycles + (3 + gap) per byte.
      for (int r = 0; r < 12; r++) begin
         do_reset();
         len = int'($urandom_range(1, 24));
         exp_c = 2;
         for (int k = 0; k < len; k++) begin
            exp_bytes[k] = 8'($urandom);
            gaps[k] = int'($urandom_range(0, 3));
            exp_c += 3 + gaps[k];
         end
         run_load(len, c);
         check("rand_cycles", c, exp_c);
         $display("random %0d: len=%0d cycles=%0d expected=%0d", r, len, c, exp_c);
      end

      // Reset during the write pulse of byte 3 of a 16-byte load.
      do_reset();
      for (int k = 0; k < 16; k++) begin
         exp_bytes[k] = 8'(8'h80 + k);
         gaps[k] = 0;
      end
      wr_cnt = 0;
      loader_phase = 1'b1;
      send(8'h10, 0, t);
      send(8'h00, 0, t);
      for (int k = 0; k < 4; k++) send(exp_bytes[k], 0, t);
      @(negedge clk);
      check("pulse_high", int'(memClk), 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_memClk", int'(memClk), 0);
      check("mid_rst_memWE", int'(memWE), 0);
      check("mid_rst_cpuRun", int'(cpuRun), 0);
      check("mid_rst_rxReady", int'(rxReady), 0);
      wr_before = wr_cnt;
      check("mid_rst_writes", wr_before, 4);
      reset = 1'b0;
      #1;
      check("mid_rst_ready", int'(rxReady), 1);
      exp_bytes[0] = 8'hC3;
      exp_bytes[1] = 8'h5A;
      run_load(2, c);
      check("fresh_cycles", c, 8);
      $display("reset mid-load then fresh load: cycles=%0d", c);

      // RUN: port follows the CPU, stream is ignored.
      cpuMemAddress = 16'h0005;
      cpuMemData = 8'h3C;
      cpuMemWE = 1'b1;
      cpuMemClk = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cpuMemClk = ~cpuMemClk;
         rxValid = (i % 2 == 0);
         rxData = 8'hEE;
         #1;
         check("run_memClk", int'(memClk), int'(cpuMemClk));
         check("run_memAddress", int'(memAddress), 5);
         check("run_memWE", int'(memWE), 1);
         check("run_memData", int'(memData), 8'h3C);
         check("run_rxReady", int'(rxReady), 0);
         check("run_cpuRun", int'(cpuRun), 1);
         check("run_cpuMemQ", int'(cpuMemQ), 8'h3C);
         $display("run step %0d: memClk=%0d memAddress=%0h cpuMemQ=%0h", i, memClk, memAddress, cpuMemQ);
      end
      rxValid = 1'b0;
      check("run_mem0", int'(mem_arr[0]), 8'hC3);
      check("run_mem1", int'(mem_arr[1]), 8'h5A);

      // Reset in RUN returns the port to the loader on the next edge.
      cpuMemClk = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      check("runrst_cpuRun", int'(cpuRun), 0);
      check("runrst_memClk", int'(memClk), 0);
      check("runrst_memWE", int'(memWE), 0);
      check("runrst_memAddress", int'(memAddress), 0);
      reset = 1'b0;
      cpuMemClk = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
